alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Hardware initiator for the arithmetic unit's start/done operation protocol. Buffers operation commands (a, b, opcode) in a small FIFO and issues them one at a time. Each issue drives the operands and opcode, pulses start, and waits for done. The captured result goes out on a valid/ready response port, along with status for timeouts and division-by-zero commands that were rejected before issue.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
TIMEOUT, 64, max cycles in WAIT before aborting with timeout status

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept (= !full)
cmd_a  in  8  operand a
cmd_b  in  8  operand b
cmd_opcode  in  2  00 ADD, 01 SUB, 10 DIV, 11 MUL
alu_a  out  8  operand a to arithmetic unit
alu_b  out  8  operand b to arithmetic unit
alu_opcode  out  2  opcode to control unit
alu_start  out  1  one-cycle issue pulse
alu_done  in  1  arithmetic unit completion
alu_result  in  8  arithmetic unit result
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer ready
rsp_result  out  8  captured result (0 on error)
rsp_opcode  out  2  opcode of the completed command
rsp_status  out  2  00 ok, 01 timeout, 10 div-by-zero
busy  out  1  high in any state but IDLE, or FIFO non-empty

Behaviour:
- Reset (async, any state): FIFO emptied, FSM to IDLE, timeout counter 0.
- Outputs under reset: cmd_ready=1, alu_a/alu_b/alu_opcode=0, alu_start=0, rsp_valid=0, rsp_result=0, rsp_opcode=0, rsp_status=0, busy=0.
- FIFO push: on cmd_valid && cmd_ready. Pop: only from IDLE. When full, cmd_ready=0 even if a pop occurs that same cycle.
- FSM states:
  - IDLE: FIFO non-empty -> pop head into the operand registers. If opcode==10 and b==0, go to RESP with status 10, result 0, and no alu_start. Otherwise go to ISSUE.
  - ISSUE: alu_start=1 for exactly this cycle. Go to WAIT and clear the timeout counter.
  - WAIT: the first WAIT cycle is a blanking cycle: alu_done is ignored, which masks a stale level-high done from the previous op. From the second WAIT cycle on:
    - alu_done=1 -> capture alu_result, status 00, go to RESP.
    - Counter reaches TIMEOUT without done -> result 0, status 01, go to RESP.
  - RESP: rsp_valid=1. rsp_result, rsp_opcode and rsp_status are held stable until rsp_ready=1, then go to IDLE.
- Outside WAIT, alu_done is ignored.
- alu_a, alu_b and alu_opcode stay stable from ISSUE through the end of WAIT. They keep their last values in other states.
- Latency: a command accepted in cycle T into an empty FIFO with the FSM in IDLE gives:
  - alu_start high in cycle T+2;
  - earliest done accepted in T+4;
  - rsp_valid high in the cycle after done is accepted.
- Div-by-zero latency: rsp_valid high in T+2.
- Ordering: responses are returned strictly in command-acceptance order. One operation is outstanding at a time.
- Simultaneous events:
  - Push and pop in the same cycle (not full): both happen.
  - Done arriving on the same cycle the timeout is reached: done wins, status 00.
- Widths: all data paths are 8 bits. The result is taken as delivered by the arithmetic unit, with no saturation or checking.
- Reset mid-operation: the operation in flight is abandoned and no response is produced. A late alu_done arriving after reset is ignored, because the FSM is in IDLE.

Test Plan:
- ADD 12+5, ALU model asserts done 3 cycles after start -> alu_start high once at T+2, rsp_result=17, rsp_opcode=00, rsp_status=00.
- SUB 20-7, DIV 40/5, MUL 6*7 back-to-back, rsp_ready=1 -> responses 13, 8, 42 in order. Exactly three alu_start pulses, each followed by done before the next start.
- Hold rsp_ready=0 and push 6 commands -> cmd_ready falls once the FIFO holds DEPTH=4 entries. Releasing rsp_ready drains all entries in order, with no loss or duplication.
- DIV 40/0 -> no alu_start, rsp_status=10 and rsp_result=0 at T+2. A following ADD 1+1 completes normally with result 2.
- ALU model never asserts done -> rsp_status=01 and rsp_result=0 after 64 WAIT cycles. Separately, ALU done held high from a prior op through the first WAIT cycle -> stale done ignored, result taken from the later genuine done.
- Assert rst during WAIT -> all outputs take reset values immediately, without waiting for a clock edge. A done pulse arriving after reset produces no response, and the next command completes normally.

Source files
------------

// File: rtl/alu_cmd_sequencer_if.sv
// Command, arithmetic-unit and response signals of alu_cmd_sequencer.
// master is the sequencer's view; slave is the environment driving it.
interface alu_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [1:0] cmd_opcode;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [1:0] alu_opcode;
  logic       alu_start;
  logic       alu_done;
  logic [7:0] alu_result;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic [1:0] rsp_opcode;
  logic [1:0] rsp_status;
  logic       busy;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_opcode, alu_done, alu_result, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_opcode, alu_start,
           rsp_valid, rsp_result, rsp_opcode, rsp_status, busy
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_opcode, alu_done, alu_result, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_opcode, alu_start,
           rsp_valid, rsp_result, rsp_opcode, rsp_status, busy
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffers arithmetic commands in a FIFO and issues them one at a time over the
// start/done protocol, returning result and status on a valid/ready response port.
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_cmd_sequencer_if.master  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT - 1);
  localparam logic [1:0]    OP_DIV     = 2'b10;
  localparam logic [1:0]    ST_OK      = 2'b00;
  localparam logic [1:0]    ST_TIMEOUT = 2'b01;
  localparam logic [1:0]    ST_DIVZ    = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
  } cmd_t;

  cmd_t          mem_q [DEPTH];
  cmd_t          mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          busy_q, busy_d;
  state_e        state_q, state_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [7:0]    alu_a_q, alu_a_d;
  logic [7:0]    alu_b_q, alu_b_d;
  logic [1:0]    alu_op_q, alu_op_d;
  logic          alu_start_q, alu_start_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_result_q, rsp_result_d;
  logic [1:0]    rsp_opcode_q, rsp_opcode_d;
  logic [1:0]    rsp_status_q, rsp_status_d;
  logic          push_s;
  logic          pop_s;
  cmd_t          head_s;

  // Sequencing FSM: pop in IDLE, pulse start, wait for done or timeout, hold response.
  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    alu_start_d  = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_opcode_d = rsp_opcode_q;
    rsp_status_d = rsp_status_q;
    pop_s        = 1'b0;
    head_s       = mem_q[rd_ptr_q];
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop_s = 1'b1;
          if ((head_s.op == OP_DIV) && (head_s.b == 8'd0)) begin
            // Rejected before issue: the arithmetic unit never sees it.
            state_d      = S_RESP;
            rsp_valid_d  = 1'b1;
            rsp_result_d = 8'd0;
            rsp_opcode_d = head_s.op;
            rsp_status_d = ST_DIVZ;
          end else begin
            state_d     = S_ISSUE;
            alu_start_d = 1'b1;
            alu_a_d     = head_s.a;
            alu_b_d     = head_s.b;
            alu_op_d    = head_s.op;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        tmo_d   = '0;
      end
      S_WAIT: begin
        // tmo_q == 0 marks the blanking cycle that masks a stale done level.
        if ((tmo_q != '0) && bus.alu_done) begin
          state_d      = S_RESP;
          rsp_valid_d  = 1'b1;
          rsp_result_d = bus.alu_result;
          rsp_opcode_d = alu_op_q;
          rsp_status_d = ST_OK;
        end else if (tmo_q == TMO_LAST) begin
          state_d      = S_RESP;
          rsp_valid_d  = 1'b1;
          rsp_result_d = 8'd0;
          rsp_opcode_d = alu_op_q;
          rsp_status_d = ST_TIMEOUT;
        end else begin
          tmo_d = tmo_q + CW'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // Command FIFO bookkeeping and the registered ready/busy flags derived from it.
  always_comb begin
    push_s   = bus.cmd_valid && cmd_ready_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_opcode};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s && !pop_s) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (!push_s && pop_s) begin
      count_d = count_q - (AW + 1)'(1);
    end else begin
      count_d = count_q;
    end
    cmd_ready_d = (count_d != FULL_CNT);
    busy_d      = (state_d != S_IDLE) || (count_d != '0);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      state_q      <= S_IDLE;
      tmo_q        <= '0;
      alu_a_q      <= 8'd0;
      alu_b_q      <= 8'd0;
      alu_op_q     <= 2'd0;
      alu_start_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 8'd0;
      rsp_opcode_q <= 2'd0;
      rsp_status_q <= 2'd0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      alu_start_q  <= alu_start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_opcode_q <= rsp_opcode_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.busy       = busy_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_opcode = alu_op_q;
  assign bus.alu_start  = alu_start_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_opcode = rsp_opcode_q;
  assign bus.rsp_status = rsp_status_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small arithmetic-unit model and
// a response monitor; all expected values are hand-computed constants.
module tb_alu_cmd_sequencer;
  logic clk;
  logic rst;
  alu_cmd_sequencer_if bus();

  alu_cmd_sequencer #(.DEPTH(4), .TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ALU model controls: auto mode answers after alu_delay cycles (0 = never).
  int         alu_auto  = 1;
  int         alu_delay = 3;
  int         alu_cd    = 0;
  logic       man_done  = 1'b0;
  logic [7:0] man_res   = 8'd0;

  int          start_cnt = 0;
  int          overlap   = 0;
  logic        in_flight = 1'b0;
  logic [11:0] rsp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] alu_calc(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return (b == 8'd0) ? 8'd0 : a / b;
      default: return 8'(a * b);
    endcase
  endfunction

  // Arithmetic-unit model, driven mid-cycle.
  always @(negedge clk) begin
    if (alu_auto != 0) begin
      if (bus.alu_start) begin
        alu_cd         = alu_delay;
        bus.alu_done   = 1'b0;
        bus.alu_result = alu_calc(bus.alu_a, bus.alu_b, bus.alu_opcode);
      end else if (alu_cd > 0) begin
        alu_cd       = alu_cd - 1;
        bus.alu_done = (alu_cd == 0);
      end else begin
        bus.alu_done = 1'b0;
      end
    end else begin
      alu_cd         = 0;
      bus.alu_done   = man_done;
      bus.alu_result = man_res;
    end
  end

  // Response and issue monitor.
  always @(posedge clk) begin
    if (rst) begin
      in_flight = 1'b0;
    end else begin
      if (bus.alu_start) begin
        start_cnt++;
        if (in_flight) overlap++;
        in_flight = 1'b1;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        rsp_q.push_back({bus.rsp_result, bus.rsp_opcode, bus.rsp_status});
        in_flight = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    int n = 0;
    bus.cmd_a      = a;
    bus.cmd_b      = b;
    bus.cmd_opcode = op;
    bus.cmd_valid  = 1'b1;
    while (!bus.cmd_ready && n < 300) begin
      tick();
      n++;
    end
    check_eq("send_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input logic [7:0] res, input logic [1:0] op,
                          input logic [1:0] st);
    int n = 0;
    while (!bus.rsp_valid && n < 300) begin
      tick();
      n++;
    end
    check_eq({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    check_eq({tag, "_result"}, 32'(bus.rsp_result), 32'(res));
    check_eq({tag, "_opcode"}, 32'(bus.rsp_opcode), 32'(op));
    check_eq({tag, "_status"}, 32'(bus.rsp_status), 32'(st));
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic wait_rsp_count(input string tag, input int want);
    int n = 0;
    while (rsp_q.size() < want && n < 600) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(rsp_q.size()), 32'(want));
  endtask

  task automatic check_reset_outs(input string pfx);
    check_eq({pfx, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    check_eq({pfx, "_alu_a"}, 32'(bus.alu_a), 32'd0);
    check_eq({pfx, "_alu_b"}, 32'(bus.alu_b), 32'd0);
    check_eq({pfx, "_alu_opcode"}, 32'(bus.alu_opcode), 32'd0);
    check_eq({pfx, "_alu_start"}, 32'(bus.alu_start), 32'd0);
    check_eq({pfx, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check_eq({pfx, "_rsp_result"}, 32'(bus.rsp_result), 32'd0);
    check_eq({pfx, "_rsp_opcode"}, 32'(bus.rsp_opcode), 32'd0);
    check_eq({pfx, "_rsp_status"}, 32'(bus.rsp_status), 32'd0);
    check_eq({pfx, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Fill-test vectors: a, b, opcode and hand-computed result.
  logic [7:0] fa [6] = '{8'd3, 8'd50, 8'd9, 8'd100, 8'd200, 8'd5};
  logic [7:0] fb [6] = '{8'd4, 8'd8, 8'd3, 8'd7, 8'd100, 8'd9};
  logic [1:0] fo [6] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
  logic [7:0] fr [6] = '{8'd7, 8'd42, 8'd27, 8'd14, 8'd44, 8'd252};

  initial begin
    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_a      = 8'd0;
    bus.cmd_b      = 8'd0;
    bus.cmd_opcode = 2'd0;
    bus.rsp_ready  = 1'b0;
    tick();
    tick();
    check_reset_outs("por");
    rst = 1'b0;
    tick();

    // ADD 12+5 with done three cycles after start.
    alu_auto  = 1;
    alu_delay = 3;
    send(8'd12, 8'd5, 2'b00);
    check_eq("add_t1_start", 32'(bus.alu_start), 32'd0);
    check_eq("add_t1_busy", 32'(bus.busy), 32'd1);
    tick();
    check_eq("add_t2_start", 32'(bus.alu_start), 32'd1);
    check_eq("add_t2_alu_a", 32'(bus.alu_a), 32'd12);
    check_eq("add_t2_alu_b", 32'(bus.alu_b), 32'd5);
    tick();
    check_eq("add_t3_start", 32'(bus.alu_start), 32'd0);
    tick();
    tick();
    check_eq("add_t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    check_eq("add_t6_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    tick();
    check_eq("add_hold_result", 32'(bus.rsp_result), 32'd17);
    wait_rsp("add", 8'd17, 2'b00, 2'b00);
    check_eq("add_start_count", 32'(start_cnt), 32'd1);
    check_eq("add_rsp_dropped", 32'(bus.rsp_valid), 32'd0);

    // SUB, DIV, MUL back-to-back with the consumer always ready.
    rsp_q.delete();
    start_cnt     = 0;
    overlap       = 0;
    alu_delay     = 2;
    bus.rsp_ready = 1'b1;
    send(8'd20, 8'd7, 2'b01);
    send(8'd40, 8'd5, 2'b10);
    send(8'd6, 8'd7, 2'b11);
    wait_rsp_count("b2b_count", 3);
    if (rsp_q.size() == 3) begin
      check_eq("b2b_sub", 32'(rsp_q[0]), 32'({8'd13, 2'b01, 2'b00}));
      check_eq("b2b_div", 32'(rsp_q[1]), 32'({8'd8, 2'b10, 2'b00}));
      check_eq("b2b_mul", 32'(rsp_q[2]), 32'({8'd42, 2'b11, 2'b00}));
    end
    check_eq("b2b_starts", 32'(start_cnt), 32'd3);
    check_eq("b2b_overlap", 32'(overlap), 32'd0);
    bus.rsp_ready = 1'b0;
    tick();

    // Back-pressure: five commands fit (one in flight plus four queued).
    rsp_q.delete();
    for (int i = 0; i < 5; i++) begin
      send(fa[i], fb[i], fo[i]);
      if (i == 3) check_eq("fill_ready_at3", 32'(bus.cmd_ready), 32'd1);
    end
    check_eq("fill_ready_full", 32'(bus.cmd_ready), 32'd0);
    tick();
    tick();
    check_eq("fill_ready_still", 32'(bus.cmd_ready), 32'd0);
    check_eq("fill_busy", 32'(bus.busy), 32'd1);
    bus.rsp_ready = 1'b1;
    send(fa[5], fb[5], fo[5]);
    wait_rsp_count("fill_count", 6);
    if (rsp_q.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check_eq($sformatf("fill_rsp%0d", i), 32'(rsp_q[i]), 32'({fr[i], fo[i], 2'b00}));
      end
    end
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    check_eq("fill_drained_busy", 32'(bus.busy), 32'd0);

    // DIV 40/0 is rejected without an issue, then ADD 1+1 runs normally.
    start_cnt = 0;
    send(8'd40, 8'd0, 2'b10);
    check_eq("dz_t1_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    check_eq("dz_t2_valid", 32'(bus.rsp_valid), 32'd1);
    check_eq("dz_t2_start", 32'(bus.alu_start), 32'd0);
    wait_rsp("dz", 8'd0, 2'b10, 2'b10);
    check_eq("dz_no_start", 32'(start_cnt), 32'd0);
    send(8'd1, 8'd1, 2'b00);
    wait_rsp("dz_next", 8'd2, 2'b00, 2'b00);

    // Timeout: unit never answers, response after 64 WAIT cycles.
    alu_delay = 0;
    send(8'd3, 8'd3, 2'b00);
    tick();
    check_eq("tmo_start", 32'(bus.alu_start), 32'd1);
    repeat (64) tick();
    check_eq("tmo_early_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    check_eq("tmo_valid", 32'(bus.rsp_valid), 32'd1);
    wait_rsp("tmo", 8'd0, 2'b00, 2'b01);

    // Stale done held high into the first WAIT cycle must be ignored.
    alu_auto = 0;
    man_done = 1'b1;
    man_res  = 8'hAA;
    send(8'd9, 8'd4, 2'b01);
    tick();
    check_eq("stale_start", 32'(bus.alu_start), 32'd1);
    tick();
    tick();
    man_done = 1'b0;
    check_eq("stale_t4_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    man_done = 1'b1;
    man_res  = 8'd5;
    tick();
    man_done = 1'b0;
    wait_rsp("stale", 8'd5, 2'b01, 2'b00);

    // Reset in WAIT: outputs clear immediately; a late done is ignored.
    send(8'd2, 8'd3, 2'b00);
    tick();
    tick();
    #1;
    rst = 1'b1;
    #1;
    check_reset_outs("midrst");
    tick();
    rst = 1'b0;
    man_done = 1'b1;
    man_res  = 8'd99;
    tick();
    man_done = 1'b0;
    repeat (4) tick();
    check_eq("late_done_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("late_done_busy", 32'(bus.busy), 32'd0);
    alu_auto  = 1;
    alu_delay = 2;
    send(8'd2, 8'd3, 2'b00);
    wait_rsp("post_rst", 8'd5, 2'b00, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
